// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between NREQ requesters, the arbiter and the single memory port.
// The arbiter attaches through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic               mem_valid;
    logic               mem_ready;
    logic [DW-1:0]      mem_data;
    logic               mem_last;
    logic [IDW-1:0]     mem_id;

    modport master (
        output req_valid, req_data, req_last, mem_ready,
        input  req_ready, mem_valid, mem_data, mem_last, mem_id
    );

    modport slave (
        input  req_valid, req_data, req_last, mem_ready,
        output req_ready, mem_valid, mem_data, mem_last, mem_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin burst-locked arbiter sharing one memory request port between NREQ requesters.
// Optional stalled-burst abort is enabled by defining ARB_BURST_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
`ifdef ARB_BURST_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic              busy
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  gnt_r;
    logic [IDW-1:0]  ptr_r;
    logic            busy_r;
    logic [IDW-1:0]  next_gnt_s;
    logic            active_s;
    logic            gnt_valid_s;
    logic            gnt_last_s;
    logic [DW-1:0]   gnt_data_s;
    logic            handshake_s;

`ifdef ARB_BURST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_r;
    logic            timeout_r;
`endif

    // First valid requester scanning ptr+1, ptr+2, ... modulo NREQ
    function automatic logic [IDW-1:0] next_grant(input logic [IDW-1:0] ptr,
                                                  input logic [NREQ-1:0] valid);
        logic [IDW-1:0] g;
        logic           found;
        int             idx;
        g     = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && valid[idx]) begin
                g     = IDW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return g;
    endfunction

    // Combinational beat forwarding from the granted requester
    always_comb begin
        // Gating with reset_n stops beats in the very cycle reset is asserted
        active_s      = (state_r == BURST) && reset_n;
        gnt_valid_s   = bus.req_valid[gnt_r];
        gnt_last_s    = bus.req_last[gnt_r];
        gnt_data_s    = bus.req_data[int'(gnt_r) * DW +: DW];
        next_gnt_s    = next_grant(ptr_r, bus.req_valid);
        bus.req_ready = '0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        bus.mem_last  = 1'b0;
        if (active_s) begin
            bus.mem_valid        = gnt_valid_s;
            bus.mem_data         = gnt_data_s;
            bus.mem_last         = gnt_last_s;
            bus.req_ready[gnt_r] = bus.mem_ready;
        end else begin
            bus.req_ready = '0;
        end
        handshake_s = active_s && gnt_valid_s && bus.mem_ready;
    end

    assign bus.mem_id = gnt_r;
    assign busy       = busy_r;
`ifdef ARB_BURST_TIMEOUT_EN
    assign timeout    = timeout_r;
`endif

    // Arbitration FSM: grant in IDLE, hold it through BURST until the last beat
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            gnt_r     <= '0;
            ptr_r     <= IDW'(NREQ - 1);
            busy_r    <= 1'b0;
`ifdef ARB_BURST_TIMEOUT_EN
            cnt_r     <= '0;
            timeout_r <= 1'b0;
`endif
        end else begin
`ifdef ARB_BURST_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (|bus.req_valid) begin
                        gnt_r   <= next_gnt_s;
                        state_r <= BURST;
                        busy_r  <= 1'b1;
`ifdef ARB_BURST_TIMEOUT_EN
                        cnt_r   <= '0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BURST: begin
                    if (handshake_s) begin
`ifdef ARB_BURST_TIMEOUT_EN
                        cnt_r <= '0;
`endif
                        if (gnt_last_s) begin
                            state_r <= IDLE;
                            ptr_r   <= gnt_r;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= BURST;
                        end
`ifdef ARB_BURST_TIMEOUT_EN
                    end else if (cnt_r == CW'(TIMEOUT)) begin
                        // Stalled too long: drop the grant, last holder goes to lowest priority
                        state_r   <= IDLE;
                        ptr_r     <= gnt_r;
                        busy_r    <= 1'b0;
                        timeout_r <= 1'b1;
                        cnt_r     <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
`else
                    end else begin
                        state_r <= BURST;
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester queues drive beats, expected beats
// are queued in predicted grant order and compared as the memory port accepts them.
module tb_mem_port_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
`ifdef ARB_BURST_TIMEOUT_EN
    logic timeout;
`endif

    mem_port_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

    mem_port_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
`ifdef ARB_BURST_TIMEOUT_EN
        .timeout (timeout),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    beat_t           rq [NREQ][$];
    exp_t            exp_q [$];
    int              hs_cyc [$];
    logic [NREQ-1:0] hold;
    logic [NREQ-1:0] fire;
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc_cnt  = 0;
    int              hs_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int r, input int b);
        logic [DW-1:0] v;
        v        = 32'hA000_0000;
        v[23:16] = 8'(r);
        v[15:0]  = 16'(b);
        return v;
    endfunction

    // Queue a burst on requester r and its expected beats on the scoreboard
    task automatic send(input int r, input int nbeats, input int tag);
        beat_t x;
        exp_t  e;
        for (int b = 0; b < nbeats; b++) begin
            x.data = mk_data(r, tag + b);
            x.last = (b == nbeats - 1);
            rq[r].push_back(x);
            e.id   = IDW'(r);
            e.data = x.data;
            e.last = x.last;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                bus.req_valid[i]           = !hold[i];
                bus.req_data[i*DW +: DW]   = rq[i][0].data;
                bus.req_last[i]            = rq[i][0].last;
            end else begin
                bus.req_valid[i]           = 1'b0;
                bus.req_data[i*DW +: DW]   = '0;
                bus.req_last[i]            = 1'b0;
            end
        end
    endtask

    // Advance one clock: retire accepted beats after the edge, return at the negedge
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        drive();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
        check_val(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_left(input int left);
        for (int n = 0; n < 100 && exp_q.size() > left; n++) tick();
        check_val("wait_left", 64'(exp_q.size()), 64'(left));
    endtask

    // Monitor just before each rising edge: record handshakes and score accepted beats
    always @(negedge clk) begin
        exp_t e;
        #4;
        cyc_cnt++;
        fire = bus.req_valid & bus.req_ready;
        if (reset_n && bus.mem_valid && bus.mem_ready) begin
            hs_cnt++;
            hs_cyc.push_back(cyc_cnt);
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("beat_id",   64'(bus.mem_id),   64'(e.id));
                check_val("beat_data", 64'(bus.mem_data), 64'(e.data));
                check_val("beat_last", 64'(bus.mem_last), 64'(e.last));
            end
        end
    end

    initial begin
        int   base;
        int   ok;
        exp_t e;
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        hold          = '0;
        fire          = '0;

        // Reset with every requester valid; these beats then exercise round-robin
        send(0, 1, 0); send(1, 1, 0); send(2, 1, 0); send(3, 1, 0); send(0, 1, 1);
        drive();
        tick(); tick();
        check_val("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_val("rst_busy",      64'(busy),          64'd0);
        check_val("rst_mem_id",    64'(bus.mem_id),    64'd0);
        check_val("rst_mem_data",  64'(bus.mem_data),  64'd0);
        reset_n = 1'b1;
        #1;
        check_val("rel_busy_low", 64'(busy), 64'd0);
        hs_cyc.delete();
        tick();
        check_val("first_busy",  64'(busy),          64'd1);
        check_val("first_id",    64'(bus.mem_id),    64'd0);
        check_val("first_valid", 64'(bus.mem_valid), 64'd1);
        drain("rr_drain");
        for (int k = 0; k < 4; k++) begin
            check_val("rr_gap", (hs_cyc.size() > k + 1) ? 64'(hs_cyc[k+1] - hs_cyc[k]) : 64'd0, 64'd2);
        end
        tick();
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_id_hold", 64'(bus.mem_id), 64'd0);

        // Burst lock: requester 1 four beats, requester 2 waiting
        hs_cyc.delete();
        send(1, 4, 16); send(2, 1, 32);
        drive();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            if (busy && bus.mem_id == IDW'(1)) check_val("lock_rdy2", 64'(bus.req_ready[2]), 64'd0);
            tick();
        end
        check_val("lock_drain", 64'(exp_q.size()), 64'd0);
        check_val("lock_consec", (hs_cyc.size() >= 4) ? 64'(hs_cyc[3] - hs_cyc[0]) : 64'd0, 64'd3);

        // Backpressure mid-burst on requester 0
        send(0, 3, 48);
        drive();
        wait_left(2);
        bus.mem_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val("bp_valid", 64'(bus.mem_valid),    64'd1);
            check_val("bp_id",    64'(bus.mem_id),       64'd0);
            check_val("bp_data",  64'(bus.mem_data),     64'(mk_data(0, 49)));
            check_val("bp_ready", 64'(bus.req_ready[0]), 64'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        base = hs_cnt;
        tick();
        check_val("bp_resume", 64'(hs_cnt - base), 64'd1);
        drain("bp_drain");

        // Valid gap on granted requester 3 while requester 0 waits
        send(3, 3, 64); send(0, 1, 80);
        drive();
        wait_left(2 + 1);
        hold[3] = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val("gap_valid", 64'(bus.mem_valid),    64'd0);
            check_val("gap_id",    64'(bus.mem_id),       64'd3);
            check_val("gap_rdy0",  64'(bus.req_ready[0]), 64'd0);
            tick();
        end
        hold[3] = 1'b0;
        drive();
        drain("gap_drain");

        // Long stall on requester 1 with requester 2 pending
        send(1, 2, 96); send(2, 1, 112);
        drive();
        wait_left(2);
        hold[1] = 1'b1;
        drive();
`ifdef ARB_BURST_TIMEOUT_EN
        ok = 0;
        for (int n = 0; n < 40 && ok == 0; n++) begin
            tick();
            if (timeout) ok = 1;
        end
        check_val("to_seen", 64'(ok), 64'd1);
        check_val("to_busy", 64'(busy), 64'd0);
        e = exp_q.pop_front();
        exp_q.push_back(e);
        tick();
        check_val("to_pulse", 64'(timeout), 64'd0);
`else
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (busy && bus.mem_id == IDW'(1) && !bus.mem_valid) ok++;
        end
        check_val("stall_hold", 64'(ok), 64'd100);
`endif
        hold[1] = 1'b0;
        drive();
        drain("stall_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
